// File: rtl/d_mem_region_ctrl.sv
// d_mem_region_ctrl: decodes one core data request per cycle into the
// CR, VGA or cache region. It stalls while the cache is busy or owes a
// read response, and returns one registered read response at Q105H.
module d_mem_region_ctrl #(
    parameter logic [31:0] CR_LO    = 32'h00FE_0000,
    parameter logic [31:0] CR_HI    = 32'h00FE_FFFF,
    parameter logic [31:0] VGA_LO   = 32'h00FF_0000,
    parameter logic [31:0] VGA_HI   = 32'h00FF_FFFF,
    parameter logic [31:0] CACHE_LO = 32'h0001_0000,
    parameter logic [31:0] CACHE_HI = 32'h00FD_FFFF
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic        ReqRdEnQ103H,
    input  logic        ReqWrEnQ103H,
    input  logic [31:0] ReqAddrQ103H,
    input  logic [31:0] ReqDataQ103H,
    input  logic [3:0]  ReqByteEnQ103H,
    output logic        DMemReady,
    output logic [31:0] DMemRdRspQ105H,
    output logic        DMemRdRspValidQ105H,
    output logic        DMemErr,
    output logic        CacheReqValid,
    output logic        CacheReqWr,
    output logic [31:0] CacheReqAddr,
    output logic [31:0] CacheReqData,
    output logic [3:0]  CacheReqByteEn,
    input  logic        CacheReady,
    input  logic        CacheRspValid,
    input  logic [31:0] CacheRspData,
    output logic        CrRdEn,
    output logic        CrWrEn,
    output logic [31:0] CrAddr,
    output logic [31:0] CrData,
    input  logic [31:0] CrRdData,
    output logic        VgaRdEn,
    output logic        VgaWrEn,
    output logic [31:0] VgaAddr,
    output logic [31:0] VgaData,
    output logic [3:0]  VgaByteEn,
    input  logic [31:0] VgaRdData
);

    typedef enum logic {ST_IDLE, ST_C_WAIT} state_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_CR, SEL_VGA, SEL_ZERO} sel_t;

    state_t state, state_nxt;
    sel_t   sel_q104;

    logic hit_cr, hit_vga, hit_cache, unmapped;
    logic req, is_rd, is_wr, both, accept;

    // Region decode (CR > VGA > cache) and acceptance handshake.
    always_comb begin
        hit_cr    = (ReqAddrQ103H >= CR_LO) && (ReqAddrQ103H <= CR_HI);
        hit_vga   = !hit_cr && (ReqAddrQ103H >= VGA_LO) && (ReqAddrQ103H <= VGA_HI);
        hit_cache = !hit_cr && !hit_vga &&
                    (ReqAddrQ103H >= CACHE_LO) && (ReqAddrQ103H <= CACHE_HI);
        unmapped  = !hit_cr && !hit_vga && !hit_cache;
        req       = ReqRdEnQ103H | ReqWrEnQ103H;
        is_wr     = ReqWrEnQ103H;
        is_rd     = ReqRdEnQ103H & ~ReqWrEnQ103H;
        both      = ReqRdEnQ103H & ReqWrEnQ103H;
        DMemReady = (state == ST_IDLE) && !(req && hit_cache && !CacheReady);
        accept    = req && DMemReady && Rst;
    end

    // Region request ports: enables only on acceptance, payload passed through.
    always_comb begin
        CacheReqValid  = accept && hit_cache;
        CacheReqWr     = is_wr;
        CacheReqAddr   = ReqAddrQ103H;
        CacheReqData   = ReqDataQ103H;
        CacheReqByteEn = ReqByteEnQ103H;
        CrRdEn         = accept && hit_cr && is_rd;
        CrWrEn         = accept && hit_cr && is_wr;
        CrAddr         = ReqAddrQ103H;
        CrData         = ReqDataQ103H;
        VgaRdEn        = accept && hit_vga && is_rd;
        VgaWrEn        = accept && hit_vga && is_wr;
        VgaAddr        = ReqAddrQ103H;
        VgaData        = ReqDataQ103H;
        VgaByteEn      = ReqByteEnQ103H;
    end

    // Next-state logic: only an accepted cache read waits for a response.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept && hit_cache && is_rd) state_nxt = ST_C_WAIT;
            ST_C_WAIT: if (CacheRspValid) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (!Rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Q104H source select for fixed-latency reads (CR, VGA, unmapped zero).
    always_ff @(posedge Clock) begin
        if (!Rst)
            sel_q104 <= SEL_NONE;
        else if (accept && is_rd && hit_cr)
            sel_q104 <= SEL_CR;
        else if (accept && is_rd && hit_vga)
            sel_q104 <= SEL_VGA;
        else if (accept && is_rd && unmapped)
            sel_q104 <= SEL_ZERO;
        else
            sel_q104 <= SEL_NONE;
    end

    // Q105H response register; data holds between responses.
    always_ff @(posedge Clock) begin
        if (!Rst) begin
            DMemRdRspQ105H      <= '0;
            DMemRdRspValidQ105H <= 1'b0;
        end else begin
            DMemRdRspValidQ105H <= 1'b0;
            case (sel_q104)
                SEL_CR: begin
                    DMemRdRspQ105H      <= CrRdData;
                    DMemRdRspValidQ105H <= 1'b1;
                end
                SEL_VGA: begin
                    DMemRdRspQ105H      <= VgaRdData;
                    DMemRdRspValidQ105H <= 1'b1;
                end
                SEL_ZERO: begin
                    DMemRdRspQ105H      <= '0;
                    DMemRdRspValidQ105H <= 1'b1;
                end
                default: begin
                    if (state == ST_C_WAIT && CacheRspValid) begin
                        DMemRdRspQ105H      <= CacheRspData;
                        DMemRdRspValidQ105H <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Sticky error: rd+wr collision, unmapped access, or stray cache response.
    always_ff @(posedge Clock) begin
        if (!Rst)
            DMemErr <= 1'b0;
        else if ((accept && (both || unmapped)) || (state == ST_IDLE && CacheRspValid))
            DMemErr <= 1'b1;
    end

endmodule

// File: tb/tb_d_mem_region_ctrl.sv
// Randomized bench with a transaction-level reference model plus directed
// scenarios carrying hand-computed literal expectations.
module tb_d_mem_region_ctrl;

    logic        Clock = 1'b0;
    logic        Rst;
    logic        ReqRdEnQ103H, ReqWrEnQ103H;
    logic [31:0] ReqAddrQ103H, ReqDataQ103H;
    logic [3:0]  ReqByteEnQ103H;
    logic        DMemReady;
    logic [31:0] DMemRdRspQ105H;
    logic        DMemRdRspValidQ105H, DMemErr;
    logic        CacheReqValid, CacheReqWr;
    logic [31:0] CacheReqAddr, CacheReqData;
    logic [3:0]  CacheReqByteEn;
    logic        CacheReady, CacheRspValid;
    logic [31:0] CacheRspData;
    logic        CrRdEn, CrWrEn;
    logic [31:0] CrAddr, CrData, CrRdData;
    logic        VgaRdEn, VgaWrEn;
    logic [31:0] VgaAddr, VgaData, VgaRdData;
    logic [3:0]  VgaByteEn;

    int checks = 0;
    int errors = 0;

    d_mem_region_ctrl dut (
        .Clock(Clock), .Rst(Rst),
        .ReqRdEnQ103H(ReqRdEnQ103H), .ReqWrEnQ103H(ReqWrEnQ103H),
        .ReqAddrQ103H(ReqAddrQ103H), .ReqDataQ103H(ReqDataQ103H),
        .ReqByteEnQ103H(ReqByteEnQ103H), .DMemReady(DMemReady),
        .DMemRdRspQ105H(DMemRdRspQ105H), .DMemRdRspValidQ105H(DMemRdRspValidQ105H),
        .DMemErr(DMemErr), .CacheReqValid(CacheReqValid), .CacheReqWr(CacheReqWr),
        .CacheReqAddr(CacheReqAddr), .CacheReqData(CacheReqData),
        .CacheReqByteEn(CacheReqByteEn), .CacheReady(CacheReady),
        .CacheRspValid(CacheRspValid), .CacheRspData(CacheRspData),
        .CrRdEn(CrRdEn), .CrWrEn(CrWrEn), .CrAddr(CrAddr), .CrData(CrData),
        .CrRdData(CrRdData), .VgaRdEn(VgaRdEn), .VgaWrEn(VgaWrEn),
        .VgaAddr(VgaAddr), .VgaData(VgaData), .VgaByteEn(VgaByteEn),
        .VgaRdData(VgaRdData)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Region of an address: 0=CR, 1=VGA, 2=cache, 3=unmapped.
    function automatic int region(input logic [31:0] a);
        if (a >= 32'h00FE_0000 && a <= 32'h00FE_FFFF) return 0;
        if (a >= 32'h00FF_0000 && a <= 32'h00FF_FFFF) return 1;
        if (a >= 32'h0001_0000 && a <= 32'h00FD_FFFF) return 2;
        return 3;
    endfunction

    // Reference model: outstanding responses with due cycle and data source
    // (0 = data known, 1 = CR read data, 2 = VGA read data sampled the cycle before due).
    typedef struct {
        int          due;
        int          src;
        logic [31:0] data;
    } rsp_t;

    rsp_t        pend[$];
    bit          m_busy = 0;
    bit          m_err = 0;
    logic [31:0] m_last = '0;
    bit          armed = 0;
    int          cyc = 0;

    // Compare process: sample mid-cycle, check all outputs, then advance the model.
    always @(negedge Clock) begin
        int          rg;
        bit          req, rd_only, both, e_ready, acc, e_valid, nbusy;
        logic [31:0] e_data;
        int          idx;

        rg      = region(ReqAddrQ103H);
        req     = ReqRdEnQ103H || ReqWrEnQ103H;
        rd_only = ReqRdEnQ103H && !ReqWrEnQ103H;
        both    = ReqRdEnQ103H && ReqWrEnQ103H;
        e_ready = !m_busy && !(req && rg == 2 && !CacheReady);
        acc     = req && e_ready && (Rst == 1'b1);

        idx = -1;
        foreach (pend[i]) if (pend[i].due == cyc) idx = i;
        if (idx >= 0) begin
            e_valid = 1;
            e_data  = pend[idx].data;
            pend.delete(idx);
            m_last  = e_data;
        end else begin
            e_valid = 0;
            e_data  = m_last;
        end

        if (armed) begin
            check("ready", {31'b0, DMemReady}, {31'b0, e_ready});
            check("cache_valid", {31'b0, CacheReqValid}, {31'b0, acc && rg == 2});
            check("cr_rden", {31'b0, CrRdEn}, {31'b0, acc && rg == 0 && rd_only});
            check("cr_wren", {31'b0, CrWrEn}, {31'b0, acc && rg == 0 && ReqWrEnQ103H});
            check("vga_rden", {31'b0, VgaRdEn}, {31'b0, acc && rg == 1 && rd_only});
            check("vga_wren", {31'b0, VgaWrEn}, {31'b0, acc && rg == 1 && ReqWrEnQ103H});
            check("rsp_valid", {31'b0, DMemRdRspValidQ105H}, {31'b0, e_valid});
            check("rsp_data", DMemRdRspQ105H, e_data);
            check("err", {31'b0, DMemErr}, {31'b0, m_err});
            if (acc && rg == 2) begin
                check("cache_wr", {31'b0, CacheReqWr}, {31'b0, ReqWrEnQ103H});
                check("cache_addr", CacheReqAddr, ReqAddrQ103H);
                check("cache_data", CacheReqData, ReqDataQ103H);
                check("cache_be", {28'b0, CacheReqByteEn}, {28'b0, ReqByteEnQ103H});
            end
            if (acc && rg == 0) begin
                check("cr_addr", CrAddr, ReqAddrQ103H);
                check("cr_data", CrData, ReqDataQ103H);
            end
            if (acc && rg == 1) begin
                check("vga_addr", VgaAddr, ReqAddrQ103H);
                check("vga_data", VgaData, ReqDataQ103H);
                check("vga_be", {28'b0, VgaByteEn}, {28'b0, ReqByteEnQ103H});
            end
        end

        if (Rst !== 1'b1) begin
            pend.delete();
            m_busy = 0;
            m_err  = 0;
            m_last = '0;
            armed  = 1;
        end else begin
            foreach (pend[i]) begin
                if (pend[i].due == cyc + 1 && pend[i].src == 1) pend[i].data = CrRdData;
                if (pend[i].due == cyc + 1 && pend[i].src == 2) pend[i].data = VgaRdData;
                if (pend[i].due == cyc + 1) pend[i].src = 0;
            end
            nbusy = m_busy;
            if (CacheRspValid && m_busy) begin
                pend.push_back('{due: cyc + 1, src: 0, data: CacheRspData});
                nbusy = 0;
            end
            if (CacheRspValid && !m_busy) m_err = 1;
            if (acc && rd_only) begin
                case (rg)
                    0: pend.push_back('{due: cyc + 2, src: 1, data: 32'h0});
                    1: pend.push_back('{due: cyc + 2, src: 2, data: 32'h0});
                    2: nbusy = 1;
                    default: pend.push_back('{due: cyc + 2, src: 0, data: 32'h0});
                endcase
            end
            if (acc && (both || rg == 3)) m_err = 1;
            m_busy = nbusy;
        end
        cyc++;
    end

    task automatic idle_inputs();
        Rst            = 1'b1;
        ReqRdEnQ103H   = 1'b0;
        ReqWrEnQ103H   = 1'b0;
        ReqAddrQ103H   = $urandom;
        ReqDataQ103H   = $urandom;
        ReqByteEnQ103H = 4'($urandom);
        CacheReady     = 1'b1;
        CacheRspValid  = 1'b0;
        CacheRspData   = $urandom;
        CrRdData       = $urandom;
        VgaRdData      = $urandom;
    endtask

    // Advance to the next cycle and drive it idle; caller then overrides fields.
    task automatic step();
        @(posedge Clock);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            Rst = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0: return 32'h00FE_0000 + 32'($urandom_range(0, 32'hFFFF));
            1: return 32'h00FF_0000 + 32'($urandom_range(0, 32'hFFFF));
            2: return 32'h0000_0000 + 32'($urandom_range(0, 32'hFFFF));
            3: return 32'h0100_0000 + 32'($urandom);
            default: return 32'h0001_0000 + 32'($urandom_range(0, 32'h00FC_FFFF));
        endcase
    endfunction

    initial begin
        idle_inputs();
        Rst = 1'b0;
        do_reset(3);

        // CR read with fixed two-cycle response.
        step();
        ReqRdEnQ103H = 1; ReqAddrQ103H = 32'h00FE_0010;
        #1 check("lit_cr_rden", {31'b0, CrRdEn}, 32'd1);
        step();
        CrRdData = 32'hCAFE_0001;
        step();
        #1 check("lit_cr_valid", {31'b0, DMemRdRspValidQ105H}, 32'd1);
        check("lit_cr_data", DMemRdRspQ105H, 32'hCAFE_0001);

        // Cache read, response four cycles later.
        step();
        ReqRdEnQ103H = 1; ReqAddrQ103H = 32'h0001_0000;
        #1 check("lit_c_valid", {31'b0, CacheReqValid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            #1 check("lit_c_stall", {31'b0, DMemReady}, 32'd0);
        end
        step();
        CacheRspValid = 1; CacheRspData = 32'h1234_5678;
        #1 check("lit_c_stall_last", {31'b0, DMemReady}, 32'd0);
        step();
        #1 check("lit_c_ready_back", {31'b0, DMemReady}, 32'd1);
        check("lit_c_rsp_valid", {31'b0, DMemRdRspValidQ105H}, 32'd1);
        check("lit_c_rsp_data", DMemRdRspQ105H, 32'h1234_5678);

        // Cache write held off by CacheReady=0 for three cycles.
        for (int i = 0; i < 4; i++) begin
            step();
            ReqWrEnQ103H = 1; ReqAddrQ103H = 32'h0002_0040;
            CacheReady = (i == 3);
            #1 check("lit_w_ready", {31'b0, DMemReady}, (i == 3) ? 32'd1 : 32'd0);
            check("lit_w_valid", {31'b0, CacheReqValid}, (i == 3) ? 32'd1 : 32'd0);
        end

        // Back-to-back VGA reads.
        step();
        ReqRdEnQ103H = 1; ReqAddrQ103H = 32'h00FF_0000;
        step();
        ReqRdEnQ103H = 1; ReqAddrQ103H = 32'h00FF_0004; VgaRdData = 32'hA1A1_0000;
        step();
        VgaRdData = 32'hA2A2_0004;
        #1 check("lit_vga0_valid", {31'b0, DMemRdRspValidQ105H}, 32'd1);
        check("lit_vga0_data", DMemRdRspQ105H, 32'hA1A1_0000);
        step();
        #1 check("lit_vga1_valid", {31'b0, DMemRdRspValidQ105H}, 32'd1);
        check("lit_vga1_data", DMemRdRspQ105H, 32'hA2A2_0004);
        check("lit_err_clean", {31'b0, DMemErr}, 32'd0);

        // Unmapped read returns zero and sets the sticky error.
        step();
        ReqRdEnQ103H = 1; ReqAddrQ103H = 32'h0000_0100;
        #1 check("lit_um_en", {28'b0, CacheReqValid, CrRdEn, VgaRdEn, 1'b0}, 32'd0);
        step();
        #1 check("lit_um_err", {31'b0, DMemErr}, 32'd1);
        step();
        #1 check("lit_um_valid", {31'b0, DMemRdRspValidQ105H}, 32'd1);
        check("lit_um_data", DMemRdRspQ105H, 32'h0);
        for (int i = 0; i < 3; i++) step();
        #1 check("lit_um_sticky", {31'b0, DMemErr}, 32'd1);

        // Reset while waiting on the cache; the late response is stray.
        do_reset(1);
        step();
        ReqRdEnQ103H = 1; ReqAddrQ103H = 32'h0003_0000;
        step();
        Rst = 0;
        #1 check("lit_rst_wait", {31'b0, DMemReady}, 32'd0);
        step();
        CacheRspValid = 1; CacheRspData = 32'hDEAD_BEEF;
        #1 check("lit_rst_ready", {31'b0, DMemReady}, 32'd1);
        check("lit_rst_err", {31'b0, DMemErr}, 32'd0);
        step();
        #1 check("lit_stray_valid", {31'b0, DMemRdRspValidQ105H}, 32'd0);
        check("lit_stray_err", {31'b0, DMemErr}, 32'd1);

        // Randomized traffic against the model.
        do_reset(2);
        for (int n = 0; n < 4000; n++) begin
            int r;
            step();
            if ($urandom_range(0, 299) == 0) Rst = 0;
            r = $urandom_range(0, 15);
            ReqAddrQ103H = rand_addr();
            if (r < 5) ReqRdEnQ103H = 1;
            else if (r < 9) ReqWrEnQ103H = 1;
            else if (r == 9 && $urandom_range(0, 3) == 0) begin
                ReqRdEnQ103H = 1; ReqWrEnQ103H = 1;
            end
            CacheReady    = ($urandom_range(0, 3) != 0);
            CacheRspValid = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
        end
        step();
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
